// File: rtl/overlay_motion_controller.sv
// Moves the overlay sprite one step per debounced key press, applied only during vertical blanking.
// Optional build macro AUTO_MOVE_EN: move every frame, key press toggles a pause flag instead.
module overlay_motion_controller #(
    parameter int H_ACTIVE  = 1920,
    parameter int V_ACTIVE  = 1080,
    parameter int SPRITE_W  = 16,
    parameter int SPRITE_H  = 32,
    parameter int STEP_X    = 10,
    parameter int STEP_Y    = 18,
    parameter int X_INIT    = 300,
    parameter int Y_INIT    = 500,
    parameter int DB_CYCLES = 50000
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    input  logic [11:0] x_counter,
    input  logic [11:0] y_counter,
    input  logic        KEY_1,
    output logic        overlay_enable,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output logic        busy
);

    localparam int              DB_W     = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [11:0]     X_MAX    = 12'(H_ACTIVE - SPRITE_W);
    localparam logic [11:0]     Y_MAX    = 12'(V_ACTIVE - SPRITE_H);
    localparam logic [10:0]     X_MAX11  = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0]     Y_MAX11  = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [11:0]     STEP_X12 = 12'(STEP_X);
    localparam logic [11:0]     STEP_Y12 = 12'(STEP_Y);
    localparam logic [10:0]     STEP_X11 = 11'(STEP_X);
    localparam logic [10:0]     STEP_Y11 = 11'(STEP_Y);
    localparam logic [11:0]     SPR_W12  = 12'(SPRITE_W);
    localparam logic [11:0]     SPR_H12  = 12'(SPRITE_H);
    localparam logic [11:0]     V_LINE   = 12'(V_ACTIVE);
    localparam logic [10:0]     X_RESET  = 11'(X_INIT);
    localparam logic [10:0]     Y_RESET  = 11'(Y_INIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP_X,
        ST_STEP_Y
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              key_meta;
    logic              key_sync;
    logic              key_db;
    logic              key_db_d;
    logic [DB_W-1:0]   db_count;
    logic              press;
    logic              frame_tick;
    logic              go;
    logic              dir_x;
    logic              dir_y;
    logic [11:0]       x_plus;
    logic [11:0]       y_plus;
    logic [10:0]       x_minus;
    logic [10:0]       y_minus;

    // Key path: the debounced level only follows the synchronised key after DB_CYCLES differing cycles.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            key_db   <= 1'b1;
            key_db_d <= 1'b1;
            db_count <= '0;
        end else begin
            key_meta <= KEY_1;
            key_sync <= key_meta;
            key_db_d <= key_db;
            if (key_sync == key_db) begin
                db_count <= '0;
            end else if (db_count == DB_LAST) begin
                key_db   <= key_sync;
                db_count <= '0;
            end else begin
                db_count <= db_count + 1'b1;
            end
        end
    end

    assign press      = key_db_d & ~key_db;
    assign frame_tick = (x_counter == 12'd0) && (y_counter == V_LINE);

`ifdef AUTO_MOVE_EN
    logic paused;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            paused <= 1'b0;
        end else if (press) begin
            paused <= ~paused;
        end
    end

    assign go = frame_tick && !paused;
`else
    logic move_pending;

    // A press landing on the STEP_Y cycle keeps the request alive for the next frame.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            move_pending <= 1'b0;
        end else if (press) begin
            move_pending <= 1'b1;
        end else if (state == ST_STEP_Y) begin
            move_pending <= 1'b0;
        end
    end

    assign go = frame_tick && move_pending;
`endif

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (go) state_next = ST_STEP_X;
            ST_STEP_X: state_next = ST_STEP_Y;
            ST_STEP_Y: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    assign busy    = (state != ST_IDLE);
    assign x_plus  = {1'b0, x_pos} + STEP_X12;
    assign y_plus  = {1'b0, y_pos} + STEP_Y12;
    assign x_minus = x_pos - STEP_X11;
    assign y_minus = y_pos - STEP_Y11;

    // Each axis clamps to the active-area edge and reverses when a step would leave it.
    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            x_pos <= X_RESET;
            y_pos <= Y_RESET;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (state == ST_STEP_X) begin
            if (dir_x) begin
                if (x_plus > X_MAX) begin
                    x_pos <= X_MAX11;
                    dir_x <= 1'b0;
                end else begin
                    x_pos <= x_plus[10:0];
                end
            end else if (x_pos < STEP_X11) begin
                x_pos <= '0;
                dir_x <= 1'b1;
            end else begin
                x_pos <= x_minus;
            end
        end else if (state == ST_STEP_Y) begin
            if (dir_y) begin
                if (y_plus > Y_MAX) begin
                    y_pos <= Y_MAX11;
                    dir_y <= 1'b0;
                end else begin
                    y_pos <= y_plus[10:0];
                end
            end else if (y_pos < STEP_Y11) begin
                y_pos <= '0;
                dir_y <= 1'b1;
            end else begin
                y_pos <= y_minus;
            end
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            overlay_enable <= 1'b0;
        end else begin
            overlay_enable <= (x_counter >= {1'b0, x_pos}) && (x_counter < {1'b0, x_pos} + SPR_W12) &&
                              (y_counter >= {1'b0, y_pos}) && (y_counter < {1'b0, y_pos} + SPR_H12);
        end
    end

endmodule
